// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding
//
// Purpose:
//   Registers decoded operands and control between decode and execute,
//   honouring stall (hold) and flush (bubble) from the hazard unit, and
//   resolves ALU operands through a combinational forwarding network fed by
//   the MEM and WB stages.
//
// Ports:
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   stall_e, flush_e    hazard-unit hold / bubble requests (flush wins)
//   *_d                 decode-stage operands, specifiers and control
//   *_m, *_w            MEM / WB stage results, destinations, write enables
//   src_a_e, src_b_e    ALU operands after forwarding and immediate select
//   write_data_e        forwarded rt value used as store data
//   write_reg_e         destination register (rd or rt)
//   sig_*_e             registered control, valid_e marks a real instruction

module id_ex_operand_stage #(
    parameter int WIDTH     = 32,
    parameter int REG_BITS  = 5,
    parameter int CTRL_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic [WIDTH-1:0]     rd1_d,
    input  logic [WIDTH-1:0]     rd2_d,
    input  logic [WIDTH-1:0]     sign_imm_d,
    input  logic [REG_BITS-1:0]  rs_d,
    input  logic [REG_BITS-1:0]  rt_d,
    input  logic [REG_BITS-1:0]  rd_d,
    input  logic [CTRL_BITS-1:0] sig_alu_control_d,
    input  logic                 sig_alu_src_d,
    input  logic                 sig_reg_dst_d,
    input  logic                 sig_reg_write_d,
    input  logic                 sig_mem_write_d,
    input  logic                 sig_mem_to_reg_d,
    input  logic [WIDTH-1:0]     alu_result_m,
    input  logic [REG_BITS-1:0]  write_reg_m,
    input  logic                 reg_write_m,
    input  logic [WIDTH-1:0]     result_w,
    input  logic [REG_BITS-1:0]  write_reg_w,
    input  logic                 reg_write_w,
    output logic [WIDTH-1:0]     src_a_e,
    output logic [WIDTH-1:0]     src_b_e,
    output logic [CTRL_BITS-1:0] sig_alu_control_e,
    output logic [WIDTH-1:0]     write_data_e,
    output logic [REG_BITS-1:0]  write_reg_e,
    output logic                 sig_reg_write_e,
    output logic                 sig_mem_write_e,
    output logic                 sig_mem_to_reg_e,
    output logic                 valid_e
);

    logic [WIDTH-1:0]     rd1_q, rd2_q, imm_q;
    logic [REG_BITS-1:0]  rs_q, rt_q, rd_q;
    logic [CTRL_BITS-1:0] alu_ctrl_q;
    logic                 alu_src_q, reg_dst_q;
    logic                 reg_write_q, mem_write_q, mem_to_reg_q;
    logic                 valid_q;

    // Reset and flush both load an all-zero bubble; stall holds everything.
    always_ff @(posedge clk) begin
        if (!reset_n || flush_e) begin
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else if (!stall_e) begin
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= sign_imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            alu_ctrl_q   <= sig_alu_control_d;
            alu_src_q    <= sig_alu_src_d;
            reg_dst_q    <= sig_reg_dst_d;
            reg_write_q  <= sig_reg_write_d;
            mem_write_q  <= sig_mem_write_d;
            mem_to_reg_q <= sig_mem_to_reg_d;
            valid_q      <= 1'b1;
        end
    end

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
    logic [WIDTH-1:0] fwd_a, fwd_b;

    always_comb begin
        mem_hit_a = reg_write_m && (write_reg_m == rs_q) && (rs_q != '0);
        wb_hit_a  = reg_write_w && (write_reg_w == rs_q) && (rs_q != '0);
        mem_hit_b = reg_write_m && (write_reg_m == rt_q) && (rt_q != '0);
        wb_hit_b  = reg_write_w && (write_reg_w == rt_q) && (rt_q != '0);

        // MEM is the younger producer, so it wins over WB.
        fwd_a = rd1_q;
        if (mem_hit_a) begin
            fwd_a = alu_result_m;
        end else if (wb_hit_a) begin
            fwd_a = result_w;
        end

        fwd_b = rd2_q;
        if (mem_hit_b) begin
            fwd_b = alu_result_m;
        end else if (wb_hit_b) begin
            fwd_b = result_w;
        end
    end

    assign src_a_e           = fwd_a;
    assign write_data_e      = fwd_b;
    assign src_b_e           = alu_src_q ? imm_q : fwd_b;
    assign write_reg_e       = reg_dst_q ? rd_q : rt_q;
    assign sig_alu_control_e = alu_ctrl_q;
    assign sig_reg_write_e   = reg_write_q;
    assign sig_mem_write_e   = mem_write_q;
    assign sig_mem_to_reg_e  = mem_to_reg_q;
    assign valid_e           = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed self-checking bench for id_ex_operand_stage

module tb_id_ex_operand_stage;

    localparam int WIDTH     = 32;
    localparam int REG_BITS  = 5;
    localparam int CTRL_BITS = 5;
    localparam logic [CTRL_BITS-1:0] ALU_ADD = 5'd2;

    logic                 clk;
    logic                 reset_n;
    logic                 stall_e, flush_e;
    logic [WIDTH-1:0]     rd1_d, rd2_d, sign_imm_d;
    logic [REG_BITS-1:0]  rs_d, rt_d, rd_d;
    logic [CTRL_BITS-1:0] sig_alu_control_d;
    logic                 sig_alu_src_d, sig_reg_dst_d;
    logic                 sig_reg_write_d, sig_mem_write_d, sig_mem_to_reg_d;
    logic [WIDTH-1:0]     alu_result_m;
    logic [REG_BITS-1:0]  write_reg_m;
    logic                 reg_write_m;
    logic [WIDTH-1:0]     result_w;
    logic [REG_BITS-1:0]  write_reg_w;
    logic                 reg_write_w;
    logic [WIDTH-1:0]     src_a_e, src_b_e, write_data_e;
    logic [CTRL_BITS-1:0] sig_alu_control_e;
    logic [REG_BITS-1:0]  write_reg_e;
    logic                 sig_reg_write_e, sig_mem_write_e, sig_mem_to_reg_e;
    logic                 valid_e;

    int total = 0;
    int bad   = 0;

    id_ex_operand_stage #(
        .WIDTH(WIDTH), .REG_BITS(REG_BITS), .CTRL_BITS(CTRL_BITS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .sig_alu_control_d(sig_alu_control_d), .sig_alu_src_d(sig_alu_src_d),
        .sig_reg_dst_d(sig_reg_dst_d), .sig_reg_write_d(sig_reg_write_d),
        .sig_mem_write_d(sig_mem_write_d), .sig_mem_to_reg_d(sig_mem_to_reg_d),
        .alu_result_m(alu_result_m), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
        .result_w(result_w), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .sig_alu_control_e(sig_alu_control_e),
        .write_data_e(write_data_e), .write_reg_e(write_reg_e),
        .sig_reg_write_e(sig_reg_write_e), .sig_mem_write_e(sig_mem_write_e),
        .sig_mem_to_reg_e(sig_mem_to_reg_e), .valid_e(valid_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mw();
        alu_result_m = '0; write_reg_m = '0; reg_write_m = 1'b0;
        result_w     = '0; write_reg_w = '0; reg_write_w = 1'b0;
    endtask

    task automatic drive_d(input logic [WIDTH-1:0] rd1, input logic [WIDTH-1:0] rd2,
                           input logic [REG_BITS-1:0] rs, input logic [REG_BITS-1:0] rt,
                           input logic [REG_BITS-1:0] rd, input logic [CTRL_BITS-1:0] ctrl);
        rd1_d = rd1; rd2_d = rd2; rs_d = rs; rt_d = rt; rd_d = rd;
        sig_alu_control_d = ctrl;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
        clear_mw();
        drive_d(32'hDEAD_BEEF, 32'h1111_2222, 5'd7, 5'd8, 5'd9, 5'd31);
        sign_imm_d = 32'h5555_5555;
        sig_alu_src_d = 1'b1; sig_reg_dst_d = 1'b1;
        sig_reg_write_d = 1'b1; sig_mem_write_d = 1'b1; sig_mem_to_reg_d = 1'b1;
        tick();
        tick();
        total++; if (src_a_e !== '0) begin bad++; $display("FAIL reset_src_a got=%h exp=0", src_a_e); end
        total++; if (src_b_e !== '0) begin bad++; $display("FAIL reset_src_b got=%h exp=0", src_b_e); end
        total++; if (write_data_e !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", write_data_e); end
        total++; if (write_reg_e !== '0) begin bad++; $display("FAIL reset_wreg got=%h exp=0", write_reg_e); end
        total++; if (sig_alu_control_e !== '0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", sig_alu_control_e); end
        total++;
        if ({sig_reg_write_e, sig_mem_write_e, sig_mem_to_reg_e, valid_e} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {sig_reg_write_e, sig_mem_write_e, sig_mem_to_reg_e, valid_e});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_load();
        drive_d(32'd20, 32'd4, 5'd1, 5'd2, 5'd0, ALU_ADD);
        sign_imm_d = 32'd0;
        sig_alu_src_d = 1'b0; sig_reg_dst_d = 1'b0;
        sig_reg_write_d = 1'b1; sig_mem_write_d = 1'b0; sig_mem_to_reg_d = 1'b0;
        tick();
        total++; if (src_a_e !== 32'd20) begin bad++; $display("FAIL load_src_a got=%0d exp=20", src_a_e); end
        total++; if (src_b_e !== 32'd4) begin bad++; $display("FAIL load_src_b got=%0d exp=4", src_b_e); end
        total++; if (valid_e !== 1'b1) begin bad++; $display("FAIL load_valid got=%b exp=1", valid_e); end
        total++; if (sig_alu_control_e !== ALU_ADD) begin bad++; $display("FAIL load_ctrl got=%h exp=%h", sig_alu_control_e, ALU_ADD); end
        total++; if (write_reg_e !== 5'd2) begin bad++; $display("FAIL load_wreg got=%0d exp=2", write_reg_e); end
        total++; if (sig_reg_write_e !== 1'b1) begin bad++; $display("FAIL load_regwrite got=%b exp=1", sig_reg_write_e); end
    endtask

    task automatic test_immediate();
        sig_alu_src_d = 1'b1; sign_imm_d = 32'hFFFF_FFFC; rd2_d = 32'd7;
        tick();
        total++; if (src_b_e !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_src_b got=%h exp=fffffffc", src_b_e); end
        total++; if (write_data_e !== 32'd7) begin bad++; $display("FAIL imm_wdata got=%h exp=7", write_data_e); end
        sig_alu_src_d = 1'b0; sign_imm_d = '0;
    endtask

    task automatic test_forward();
        drive_d(32'h11, 32'h22, 5'd3, 5'd4, 5'd0, ALU_ADD);
        tick();
        alu_result_m = 32'h0000_AAAA; write_reg_m = 5'd3; reg_write_m = 1'b1;
        result_w = 32'h1234; write_reg_w = 5'd3; reg_write_w = 1'b1;
        #1;
        total++; if (src_a_e !== 32'h0000_AAAA) begin bad++; $display("FAIL fwd_mem_prio got=%h exp=0000aaaa", src_a_e); end
        total++; if (write_data_e !== 32'h22) begin bad++; $display("FAIL fwd_b_nohit got=%h exp=22", write_data_e); end
        reg_write_m = 1'b0;
        #1;
        total++; if (src_a_e !== 32'h0000_1234) begin bad++; $display("FAIL fwd_wb got=%h exp=00001234", src_a_e); end
        // MEM targets rt while WB still targets rs: each operand picks its own source.
        reg_write_m = 1'b1; write_reg_m = 5'd4;
        #1;
        total++; if (write_data_e !== 32'h0000_AAAA) begin bad++; $display("FAIL fwd_b_mem got=%h exp=0000aaaa", write_data_e); end
        total++; if (src_b_e !== 32'h0000_AAAA) begin bad++; $display("FAIL fwd_srcb_mem got=%h exp=0000aaaa", src_b_e); end
        total++; if (src_a_e !== 32'h0000_1234) begin bad++; $display("FAIL fwd_a_wb2 got=%h exp=00001234", src_a_e); end
        reg_write_w = 1'b0;
        #1;
        total++; if (src_a_e !== 32'h11) begin bad++; $display("FAIL fwd_none got=%h exp=11", src_a_e); end
        clear_mw();
    endtask

    task automatic test_reg_zero();
        drive_d(32'd0, 32'h66, 5'd0, 5'd0, 5'd0, ALU_ADD);
        tick();
        alu_result_m = 32'd5; write_reg_m = 5'd0; reg_write_m = 1'b1;
        result_w = 32'd9; write_reg_w = 5'd0; reg_write_w = 1'b1;
        #1;
        total++; if (src_a_e !== 32'd0) begin bad++; $display("FAIL zero_src_a got=%h exp=0", src_a_e); end
        total++; if (write_data_e !== 32'h66) begin bad++; $display("FAIL zero_wdata got=%h exp=66", write_data_e); end
        rd1_d = 32'h33;
        tick();
        total++; if (src_a_e !== 32'h33) begin bad++; $display("FAIL zero_src_a_reg got=%h exp=33", src_a_e); end
        clear_mw();
    endtask

    task automatic test_stall_flush();
        drive_d(32'h100, 32'h200, 5'd5, 5'd6, 5'd7, 5'd3);
        sig_reg_dst_d = 1'b1; sig_reg_write_d = 1'b1; sig_mem_write_d = 1'b1; sig_mem_to_reg_d = 1'b1;
        tick();
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_d(32'h900 + i, 32'h800 + i, 5'd10 + 5'(i), 5'd20, 5'd21, 5'd9);
            sig_reg_dst_d = 1'b0; sig_reg_write_d = 1'b0; sig_mem_write_d = 1'b0;
            tick();
            total++;
            if ({src_a_e, write_data_e, write_reg_e, sig_alu_control_e, valid_e, sig_mem_write_e}
                !== {32'h100, 32'h200, 5'd7, 5'd3, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got a=%h b=%h wr=%0d ctrl=%0d v=%b mw=%b exp a=100 b=200 wr=7 ctrl=3 v=1 mw=1",
                         i, src_a_e, write_data_e, write_reg_e, sig_alu_control_e, valid_e, sig_mem_write_e);
            end
        end
        // Forwarding keeps tracking M while the registers hold.
        alu_result_m = 32'hCAFE; write_reg_m = 5'd5; reg_write_m = 1'b1;
        #1;
        total++; if (src_a_e !== 32'hCAFE) begin bad++; $display("FAIL stall_fwd got=%h exp=cafe", src_a_e); end
        alu_result_m = 32'hBEEF;
        #1;
        total++; if (src_a_e !== 32'hBEEF) begin bad++; $display("FAIL stall_fwd2 got=%h exp=beef", src_a_e); end
        clear_mw();
        flush_e = 1'b1;
        tick();
        total++;
        if ({valid_e, sig_reg_write_e, sig_mem_write_e, sig_mem_to_reg_e} !== 4'b0) begin
            bad++;
            $display("FAIL flush_flags got=%b exp=0000", {valid_e, sig_reg_write_e, sig_mem_write_e, sig_mem_to_reg_e});
        end
        total++; if (sig_alu_control_e !== '0) begin bad++; $display("FAIL flush_ctrl got=%h exp=0", sig_alu_control_e); end
        total++; if (src_a_e !== '0) begin bad++; $display("FAIL flush_src_a got=%h exp=0", src_a_e); end
        flush_e = 1'b0; stall_e = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        drive_d(32'h77, 32'h88, 5'd1, 5'd2, 5'd3, 5'd4);
        sig_reg_write_d = 1'b1;
        tick();
        stall_e = 1'b1; reset_n = 1'b0;
        tick();
        total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL rst_stall_valid got=%b exp=0", valid_e); end
        total++; if (src_a_e !== '0) begin bad++; $display("FAIL rst_stall_src_a got=%h exp=0", src_a_e); end
        total++; if (sig_reg_write_e !== 1'b0) begin bad++; $display("FAIL rst_stall_rw got=%b exp=0", sig_reg_write_e); end
        reset_n = 1'b1; stall_e = 1'b0;
    endtask

    task automatic test_dest_select();
        drive_d(32'd1, 32'd2, 5'd1, 5'd8, 5'd9, ALU_ADD);
        sig_reg_dst_d = 1'b0;
        tick();
        total++; if (write_reg_e !== 5'd8) begin bad++; $display("FAIL dst_rt got=%0d exp=8", write_reg_e); end
        sig_reg_dst_d = 1'b1;
        tick();
        total++; if (write_reg_e !== 5'd9) begin bad++; $display("FAIL dst_rd got=%0d exp=9", write_reg_e); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_d(32'h1000 * (i + 1), 32'h10 + i, 5'd1, 5'd2, 5'd3, 5'(i));
            tick();
            total++;
            if (src_a_e !== 32'h1000 * (i + 1) || write_data_e !== 32'h10 + i || sig_alu_control_e !== 5'(i)) begin
                bad++;
                $display("FAIL b2b cyc=%0d got a=%h wd=%h ctrl=%0d exp a=%h wd=%h ctrl=%0d",
                         i, src_a_e, write_data_e, sig_alu_control_e, 32'h1000 * (i + 1), 32'h10 + i, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_immediate();
        test_forward();
        test_reg_zero();
        test_stall_flush();
        test_reset_mid_stall();
        test_dest_select();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
